vedic_mult_pipe: RTL and testbench



---
 rtl/vedic_pkg.sv | 41 ++++
 rtl/vedic_combine.sv | 65 ++++++
 rtl/vedic_mult_pipe.sv | 116 +++++++++++
 tb/tb_vedic_mult_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared helpers and types for the pipelined Vedic multiplier:
// depth derivation, stage sideband and the adder/2x2 primitive cells.
package vedic_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // One pipeline stage per recursion level of a width x width product.
  function automatic int unsigned lat_of(input int unsigned width);
    return clog2(width);
  endfunction

  typedef struct packed {
    logic valid;
    logic neg;
  } sb_t;

  function automatic logic [1:0] ha(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

  // Urdhva-Tiryagbhyam 2x2 base cell: vertical, crosswise, vertical.
  function automatic logic [3:0] vedic2x2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] s1;
    logic [1:0] s2;
    s1 = ha(a[1] & b[0], a[0] & b[1]);
    s2 = ha(a[1] & b[1], s1[1]);
    return {s2[1], s2[0], s1[0], a[0] & b[0]};
  endfunction

endpackage

// File: rtl/vedic_combine.sv
// Merges four HW x HW sub-products into one 2HW x 2HW product:
// low half passes through, cross terms ripple-add, carries fold into the high half.
module vedic_combine
  import vedic_pkg::*;
#(
  parameter int unsigned HW = 2
) (
  input  logic [2*HW-1:0] ll,
  input  logic [2*HW-1:0] lh,
  input  logic [2*HW-1:0] hl,
  input  logic [2*HW-1:0] hh,
  output logic [4*HW-1:0] p
);

  logic [2*HW:0]   mid;
  logic [2*HW:0]   mid2;
  logic [2*HW:0]   ll_up;
  logic [2*HW-1:0] up;
  logic [2*HW-1:0] hi;

  assign ll_up = (2*HW+1)'(ll[2*HW-1:HW]);
  assign up    = (2*HW)'(mid2[2*HW:HW]);

  // Cross terms lh + hl.
  always_comb begin
    logic [1:0] r;
    logic       c;
    mid = '0;
    c   = 1'b0;
    for (int i = 0; i < 2*HW; i++) begin
      r      = fa(lh[i], hl[i], c);
      mid[i] = r[0];
      c      = r[1];
    end
    mid[2*HW] = c;
  end

  // Fold the upper half of ll into the cross-term sum; cannot overflow 2HW+1 bits.
  always_comb begin
    logic [1:0] r;
    logic       c;
    mid2 = '0;
    c    = 1'b0;
    for (int i = 0; i < 2*HW + 1; i++) begin
      r       = fa(mid[i], ll_up[i], c);
      mid2[i] = r[0];
      c       = r[1];
    end
  end

  always_comb begin
    logic [1:0] r;
    logic       c;
    hi = '0;
    c  = 1'b0;
    for (int i = 0; i < 2*HW; i++) begin
      r     = fa(hh[i], up[i], c);
      hi[i] = r[0];
      c     = r[1];
    end
  end

  assign p = {hi, mid2[HW-1:0], ll[HW-1:0]};

endmodule

// File: rtl/vedic_mult_pipe.sv
// Pipelined signed/unsigned Vedic multiplier with valid/ready on both sides,
// a whole-pipe stall on backpressure and an in-flight transaction counter.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned LAT   = lat_of(WIDTH),
  localparam int unsigned IFW   = clog2(LAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [IFW-1:0]     inflight
);

  logic               adv;
  logic               acc;
  logic               dlv;
  logic [WIDTH-1:0]   ma_c;
  logic [WIDTH-1:0]   mb_c;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] mag;
  sb_t                sb [LAT-1];

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign acc      = in_valid & adv;
  assign dlv      = out_valid & out_ready;

  // Magnitudes; -2^(WIDTH-1) maps onto itself as an unsigned value.
  always_comb begin
    ma_c = in_a;
    mb_c = in_b;
    if (in_signed && in_a[WIDTH-1]) ma_c = ~in_a + WIDTH'(1);
    if (in_signed && in_b[WIDTH-1]) mb_c = ~in_b + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ma <= '0;
      mb <= '0;
      for (int s = 0; s < LAT - 1; s++) sb[s] <= '0;
    end else if (adv) begin
      ma          <= ma_c;
      mb          <= mb_c;
      sb[0].valid <= in_valid;
      sb[0].neg   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      for (int s = 1; s < LAT - 1; s++) sb[s] <= sb[s-1];
    end
  end

  // Level k holds all digit-pair products of 2^k-bit digits of a and b.
  // Level 1 shares stage 1 with level 2; level LAT feeds the output stage.
  for (genvar k = 1; k <= LAT; k++) begin : g_lvl
    localparam int unsigned D = 32'd1 << k;
    localparam int unsigned N = WIDTH / D;
    logic [2*D-1:0] c [N][N];
    logic [2*D-1:0] q [N][N];

    for (genvar i = 0; i < N; i++) begin : g_i
      for (genvar j = 0; j < N; j++) begin : g_j
        if (k == 1) begin : g_base
          assign c[i][j] = vedic2x2(ma[2*i +: 2], mb[2*j +: 2]);
        end else begin : g_cmb
          vedic_combine #(.HW(D / 2)) u_cmb (
            .ll (g_lvl[k-1].q[2*i][2*j]),
            .lh (g_lvl[k-1].q[2*i][2*j+1]),
            .hl (g_lvl[k-1].q[2*i+1][2*j]),
            .hh (g_lvl[k-1].q[2*i+1][2*j+1]),
            .p  (c[i][j])
          );
        end
      end
    end

    if (k >= 2 && k < LAT) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) q[i][j] <= '0;
        end else if (adv) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) q[i][j] <= c[i][j];
        end
      end
    end else begin : g_pass
      assign q = c;
    end
  end

  assign mag = g_lvl[LAT].q[0][0];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      inflight  <= '0;
    end else begin
      if (adv) begin
        out_valid <= sb[LAT-2].valid;
        out_prod  <= sb[LAT-2].neg ? (~mag + (2*WIDTH)'(1)) : mag;
      end
      if (acc && !dlv) inflight <= inflight + IFW'(1);
      else if (dlv && !acc) inflight <= inflight - IFW'(1);
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench for vedic_mult_pipe (WIDTH=8): arithmetic reference
// queue, directed corner products, stall, mid-flight reset and random traffic.
module tb_vedic_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic [1:0]  inflight;

  logic rdy_mode = 1'b0;
  logic rdy_val  = 1'b1;
  logic rnd_rdy  = 1'b1;
  bit   mon_on   = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [15:0] expq [$];

  always #5 clk = ~clk;

  assign out_ready = rdy_mode ? rnd_rdy : rdy_val;

  vedic_mult_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .inflight  (inflight)
  );

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] ref_prod(logic [7:0] a, logic [7:0] b, logic s);
    int x;
    int y;
    if (s) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    return 16'(x * y);
  endfunction

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 6))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h7F;
      4: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  // Scoreboard: outputs vs. expected queue, counter vs. queue depth.
  always @(negedge clk) begin
    if (mon_on) begin
      check("inflight", 32'(inflight), 32'(expq.size()));
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid) begin
        check("spurious_valid", 32'(expq.size() == 0), 32'd0);
        if (expq.size() != 0) check("prod", 32'(out_prod), 32'(expq[0]));
      end
      if (rst) begin
        expq.delete();
      end else begin
        if (out_valid && out_ready && expq.size() != 0) void'(expq.pop_front());
        if (in_valid && in_ready) expq.push_back(ref_prod(in_a, in_b, in_signed));
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Present one transaction at a cycle start and hold it until accepted.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_signed = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_mode = 1'b0;
    rdy_val  = 1'b1;
    while ((expq.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(expq.size()), 32'd0);
  endtask

  task automatic directed(string nm, logic [7:0] a, logic [7:0] b, logic s, logic [15:0] exp);
    int cyc;
    check({nm, "_model"}, 32'(ref_prod(a, b, s)), 32'(exp));
    push(a, b, s);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 20);
    check({nm, "_latency"}, 32'(cyc), 32'd3);
    check({nm, "_prod"}, 32'(out_prod), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  ta [4];
    logic [7:0]  tb [4];
    logic        ts [4];
    logic [15:0] first;

    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 8'h5A;
    in_b = 8'hA5;
    in_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_prod", 32'(out_prod), 32'h0000);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    mon_on = 1'b1;

    directed("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    directed("u_00_5a", 8'h00, 8'h5A, 1'b0, 16'h0000);
    directed("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
    directed("s_ff_7f", 8'hFF, 8'h7F, 1'b1, 16'hFF81);
    directed("s_80_01", 8'h80, 8'h01, 1'b1, 16'hFF80);
    directed("u_ff_7f", 8'hFF, 8'h7F, 1'b0, 16'h7E81);
    drain();

    // Backpressure: stall for 5 cycles as soon as the first result shows.
    for (int i = 0; i < 4; i++) begin
      ta[i] = pick();
      tb[i] = pick();
      ts[i] = 1'($urandom_range(0, 1));
    end
    first = ref_prod(ta[0], tb[0], ts[0]);
    fork
      begin
        for (int i = 0; i < 4; i++) push(ta[i], tb[i], ts[i]);
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 20);
        rdy_val = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_prod", 32'(out_prod), 32'(first));
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_inflight", 32'(inflight), 32'd3);
        end
        @(posedge clk);
        #1;
        rdy_val = 1'b1;
      end
    join
    drain();

    // Reset with two transactions in flight; nothing may emerge afterwards.
    push(8'h12, 8'h34, 1'b0);
    push(8'hC3, 8'h3C, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_inflight", 32'(inflight), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_quiet", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Throughput: 20 back-to-back accepts, one result per cycle.
    fork
      begin
        for (int i = 0; i < 20; i++) push(pick(), pick(), 1'($urandom_range(0, 1)));
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 30);
        for (int i = 0; i < 18; i++) begin
          check("tput_valid", 32'(out_valid), 32'd1);
          check("tput_inflight", 32'(inflight), 32'd3);
          @(negedge clk);
        end
      end
    join
    drain();

    // Random traffic with random gaps and random consumer backpressure.
    rdy_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      push(pick(), pick(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
